// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: state encoding and
// default widths / divide ratio used by the top and the period counter.
package cpu_clk_ctrl_pkg;

    localparam int DEF_DIV_W       = 32;
    localparam int DEF_STEP_W      = 8;
    localparam int DEF_DEFAULT_DIV = 500;

    // 2'b11 is deliberately left out; the FSM folds it back into ST_HALT.
    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    // The period counter only advances while the core is being clocked.
    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_clock_controller_period_counter.sv
// Period counter: counts 0..div and emits a registered one-cycle tick on the
// edge where the count matches div. Held at zero while disabled or cleared.
module period_counter
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             terminal
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Terminal count for this edge; a clear (halt) suppresses it entirely.
    assign terminal = enable && !clear && (cnt_q == div);

    // Next count and tick: wrap only through the compare, never by overflow.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d  = '0;
        tick_d = 1'b0;
        if (enable && !clear) begin
            if (terminal) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Count and tick registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step controller producing the CPU clock-enable `tick`.
// Holds the mode FSM, the divide register (loaded over a ready/valid port
// while halted) and the remaining-steps counter for STEP bursts.
// Optional: define CPU_CLK_CTRL_DIV_CLK_EN to get a 50% duty div_clk that
// toggles on every tick; otherwise div_clk is tied low.
module cpu_clock_controller
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV,
    parameter int STEP_W      = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    output logic              tick,
    output logic              halted,
    output logic [STEP_W-1:0] steps_left,
    output logic              div_clk
);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] steps_q, steps_d;

    logic cnt_enable;
    logic cnt_clear;
    logic terminal;

    // Counter runs in RUN/STEP; a halt request discards the current period.
    assign cnt_enable = is_active(state_q);
    assign cnt_clear  = halt_req;

    period_counter #(
        .DIV_W (DIV_W)
    ) u_period_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (cnt_enable),
        .clear    (cnt_clear),
        .div      (div_q),
        .tick     (tick),
        .terminal (terminal)
    );

    // Mode transitions, divide-register load and step bookkeeping.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        steps_d = steps_q;
        unique case (state_q)
            ST_HALT: begin
                if (cfg_valid) begin
                    div_d = cfg_div;
                end
                if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_req && (step_count != '0)) begin
                    state_d = ST_STEP;
                    steps_d = step_count;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    steps_d = '0;
                end else if (terminal) begin
                    steps_d = steps_q - STEP_W'(1);
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: begin
                state_d = ST_HALT;
                steps_d = '0;
            end
        endcase
    end

    // Mode, divide and step registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_HALT;
            div_q   <= DIV_W'(DEFAULT_DIV);
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            steps_q <= steps_d;
        end
    end

    assign halted     = (state_q == ST_HALT);
    assign cfg_ready  = (state_q == ST_HALT);
    assign steps_left = steps_q;

`ifdef CPU_CLK_CTRL_DIV_CLK_EN
    logic div_clk_q, div_clk_d;

    // Toggle on each issued tick; terminal is never set in HALT, so it freezes.
    always_comb begin
        div_clk_d = div_clk_q ^ terminal;
    end

    // Square-wave output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_clk_q <= 1'b0;
        end else begin
            div_clk_q <= div_clk_d;
        end
    end

    assign div_clk = div_clk_q;
`else
    assign div_clk = 1'b0;
`endif

endmodule
